// File: rtl/alu_loader_pkg.sv
// Shared types and widths for the ALU operand loader.
package alu_loader_pkg;

    localparam int unsigned OPCODE_W = 2;
    localparam int unsigned FLAGS_W  = 5;

    // Encodings are visible on the state LEDs, so keep them fixed.
    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_loader_press_detect.sv
// Button press detector: optional two-flop synchronizer followed by a rising-edge detector.
// Macro ENTER_SYNC_EN enables the synchronizer (adds two cycles of latency).
// All flops reset to 1 so a button held through reset release never produces a press.
module press_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    logic btn_s;
    logic btn_prev;

`ifdef ENTER_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    assign btn_s = sync_2;
`else
    assign btn_s = btn;
`endif

    // Remember the previous button level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn_s;
        end
    end

    assign press = btn_s & ~btn_prev;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequential operand entry front end for the four-operation ALU: A, B and OpCode are entered
// on a shared bus with one press each, then the ALU Result/Flags are captured for display.
// Macro ENTER_SYNC_EN (optional) synchronizes the enter button before edge detection.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [M-1:0]        data_in,
    input  logic                enter,
    input  logic                clear,
    output logic [M-1:0]        A,
    output logic [M-1:0]        B,
    output logic [OPCODE_W-1:0] OpCode,
    input  logic [M-1:0]        Result_in,
    input  logic [FLAGS_W-1:0]  Flags_in,
    output logic [M-1:0]        Result_q,
    output logic [FLAGS_W-1:0]  Flags_q,
    output logic [2:0]          state,
    output logic                valid
);

    logic                press;
    state_t              state_q;
    logic [M-1:0]        a_q;
    logic [M-1:0]        b_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [M-1:0]        result_r;
    logic [FLAGS_W-1:0]  flags_r;
    logic                valid_q;

    press_detect u_press_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (enter),
        .press   (press)
    );

    // Entry FSM and all data registers; clear takes priority over any press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            result_r <= '0;
            flags_r  <= '0;
            valid_q  <= 1'b0;
        end else if (clear) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            result_r <= '0;
            flags_r  <= '0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (press) begin
                        a_q     <= data_in;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_q     <= data_in;
                        state_q <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (press) begin
                        opcode_q <= data_in[OPCODE_W-1:0];
                        state_q  <= EXEC;
                    end
                end
                // The ALU has had one full cycle on the registered operands.
                EXEC: begin
                    result_r <= Result_in;
                    flags_r  <= Flags_in;
                    valid_q  <= 1'b1;
                    state_q  <= SHOW;
                end
                SHOW: begin
                    if (press) begin
                        valid_q <= 1'b0;
                        state_q <= LOAD_A;
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign OpCode   = opcode_q;
    assign Result_q = result_r;
    assign Flags_q  = flags_r;
    assign state    = state_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: vector table of full entry sequences with a
// scoreboard for captured results, plus hand-written reset/hold/clear corner cases.
module tb_alu_operand_loader;

`ifdef ENTER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       enter;
    logic       clear;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] OpCode;
    logic [7:0] Result_in;
    logic [4:0] Flags_in;
    logic [7:0] Result_q;
    logic [4:0] Flags_q;
    logic [2:0] state;
    logic       valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_bus;
        logic [7:0] res;
        logic [4:0] flg;
        logic [1:0] exp_op;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic [4:0] flg;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];

    alu_operand_loader #(.M(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .enter     (enter),
        .clear     (clear),
        .A         (A),
        .B         (B),
        .OpCode    (OpCode),
        .Result_in (Result_in),
        .Flags_in  (Flags_in),
        .Result_q  (Result_q),
        .Flags_q   (Flags_q),
        .state     (state),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise enter with data and wait until just after the capture edge; enter stays high.
    task automatic press_begin(input logic [7:0] d);
        @(negedge clk);
        data_in = d;
        enter   = 1'b1;
        repeat (1 + LAT) @(posedge clk);
        @(negedge clk);
    endtask

    // Release enter and let the release propagate through any synchronizer.
    task automatic press_end();
        enter = 1'b0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        bit   seen;
        Result_in = v.res;
        Flags_in  = v.flg;
        press_begin(v.a);
        chk("a_state", state, 1);
        chk("a_val", A, v.a);
        press_end();
        press_begin(v.b);
        chk("b_state", state, 2);
        chk("b_val", B, v.b);
        press_end();
        press_begin(v.op_bus);
        chk("exec_state", state, 3);
        chk("exec_valid", valid, 0);
        e.a = v.a; e.b = v.b; e.op = v.exp_op; e.res = v.res; e.flg = v.flg;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("valid_seen", seen, 1);
        got = sb.pop_front();
        chk("show_state", state, 4);
        chk("opcode", OpCode, got.op);
        chk("a_hold", A, got.a);
        chk("b_hold", B, got.b);
        chk("result", Result_q, got.res);
        chk("flags", Flags_q, got.flg);
        press_end();
        // Leave SHOW; captured values must survive.
        press_begin(8'h00);
        chk("exit_valid", valid, 0);
        chk("exit_state", state, 0);
        chk("exit_result", Result_q, got.res);
        chk("exit_flags", Flags_q, got.flg);
        chk("exit_a", A, got.a);
        press_end();
    endtask

    initial begin
        vecs[0] = '{a: 8'h3C, b: 8'h15, op_bus: 8'h02, res: 8'h51, flg: 5'b00010, exp_op: 2'b10};
        vecs[1] = '{a: 8'hFF, b: 8'h01, op_bus: 8'hFD, res: 8'h00, flg: 5'b10101, exp_op: 2'b01};
        vecs[2] = '{a: 8'h00, b: 8'h00, op_bus: 8'h03, res: 8'hA5, flg: 5'b11111, exp_op: 2'b11};
        vecs[3] = '{a: 8'h80, b: 8'h7F, op_bus: 8'hFC, res: 8'hFF, flg: 5'b01000, exp_op: 2'b00};

        // Reset with enter held: no press on release.
        reset_n = 1'b0; enter = 1'b1; clear = 1'b0; data_in = 8'h77;
        Result_in = 8'h99; Flags_in = 5'b11011;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_a", A, 0);
        chk("rst_b", B, 0);
        chk("rst_op", OpCode, 0);
        chk("rst_result", Result_q, 0);
        chk("rst_flags", Flags_q, 0);
        chk("rst_valid", valid, 0);
        press_end();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Hold enter for 20 cycles in LOAD_A: exactly one advance.
        @(negedge clk);
        data_in = 8'hAA;
        enter   = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("hold_state", state, 1);
        chk("hold_a", A, 8'hAA);
        press_end();

        // Clear coinciding with the OpCode press.
        press_begin(8'h11);
        chk("pre_clr_state", state, 2);
        press_end();
        @(negedge clk);
        data_in = 8'h03;
        enter   = 1'b1;
        clear   = 1'b1;
        repeat (1 + LAT) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk("clr_state", state, 0);
        chk("clr_a", A, 0);
        chk("clr_b", B, 0);
        chk("clr_op", OpCode, 0);
        chk("clr_valid", valid, 0);
        chk("clr_result", Result_q, 0);
        press_end();
        chk("clr_no_late_press", state, 0);

        // Asynchronous reset while in LOAD_B after a completed sequence.
        run_vec(vecs[0]);
        press_begin(8'h5A);
        chk("mid_b_state", state, 1);
        press_end();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_a", A, 0);
        chk("arst_result", Result_q, 0);
        chk("arst_flags", Flags_q, 0);
        chk("arst_valid", valid, 0);
        enter = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
